// File: rtl/mux_nt1_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mux_nt1_stream                                             |
// | Description : N-to-1 valid/ready stream multiplexer with a one-beat      |
// |               registered output stage. The channel to accept is chosen   |
// |               either by an external select (MODE 0) or by a round-robin  |
// |               arbiter over the valid channels (MODE 1).                  |
// | Ports       : clk       - single clock, rising edge                      |
// |               rst_n     - synchronous active-low reset                   |
// |               in_data   - N*WIDTH packed channel data, ch i at           |
// |                           [i*WIDTH +: WIDTH]                             |
// |               in_valid  - per-channel valid                              |
// |               in_ready  - per-channel ready (at most one bit high)       |
// |               sel       - channel select, MODE 0 only                    |
// |               out_data  - registered data of the held beat               |
// |               out_valid - output register holds a beat                   |
// |               out_ready - downstream accept                              |
// |               out_chan  - source channel of the held beat                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mux_nt1_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int MODE  = 0,
   localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_chan
);

   localparam logic [SELW-1:0] c_last_chan = SELW'(N - 1);

   // output register and round-robin pointer
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_chan_q,  out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic             w_can_accept;
   logic             w_grant_ok;
   logic [SELW-1:0]  w_grant;
   logic [N-1:0]     w_in_ready;
   logic             w_xfer_in;
   logic [WIDTH-1:0] w_grant_data;

   // Reset is folded in here so no input handshake can complete while
   // rst_n is low.
   assign w_can_accept = rst_n && (!out_valid_q || out_ready);

   generate
      if (MODE == 0) begin : g_ext_sel
         // Out-of-range selects match no channel, so nothing is granted.
         always_comb begin
            w_grant    = sel;
            w_grant_ok = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (sel == i[SELW-1:0]) begin
                  w_grant_ok = 1'b1;
               end
            end
         end
      end else begin : g_round_robin
         logic w_unused_sel;
         assign w_unused_sel = ^sel;

         // First valid channel scanning ptr, ptr+1, ... modulo N.
         always_comb begin
            int idx;
            w_grant    = '0;
            w_grant_ok = 1'b0;
            idx        = 0;
            for (int k = 0; k < N; k++) begin
               idx = int'(ptr_q) + k;
               if (idx >= N) begin
                  idx = idx - N;
               end
               if (!w_grant_ok && in_valid[idx]) begin
                  w_grant    = idx[SELW-1:0];
                  w_grant_ok = 1'b1;
               end
            end
         end
      end
   endgenerate

   // One-hot ready on the granted channel; in MODE 0 this is independent
   // of that channel's valid.
   always_comb begin
      w_in_ready = '0;
      for (int i = 0; i < N; i++) begin
         w_in_ready[i] = w_can_accept && w_grant_ok && (w_grant == i[SELW-1:0]);
      end
   end

   assign in_ready  = w_in_ready;
   assign w_xfer_in = |(in_valid & w_in_ready);

   always_comb begin
      w_grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == i[SELW-1:0]) begin
            w_grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // A load takes priority over a drain, so a simultaneous drain and load
   // simply replaces the register contents with out_valid staying high.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (w_xfer_in) begin
         out_data_d  = w_grant_data;
         out_chan_d  = w_grant;
         out_valid_d = 1'b1;
         if (MODE == 1) begin
            ptr_d = (w_grant == c_last_chan) ? '0 : w_grant + SELW'(1);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nt1_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mux_nt1_stream                                          |
// | Description : Directed bench for mux_nt1_stream. Three instances:        |
// |               A = MODE 0 N=4, B = MODE 1 N=4, C = MODE 0 N=3, WIDTH=8.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mux_nt1_stream;

   logic clk;
   logic rst_n;

   // instance A: external select, 4 channels
   logic [31:0] a_in_data;
   logic [3:0]  a_in_valid, a_in_ready;
   logic [1:0]  a_sel, a_out_chan;
   logic [7:0]  a_out_data;
   logic        a_out_valid, a_out_ready;

   // instance B: round-robin, 4 channels
   logic [31:0] b_in_data;
   logic [3:0]  b_in_valid, b_in_ready;
   logic [1:0]  b_sel, b_out_chan;
   logic [7:0]  b_out_data;
   logic        b_out_valid, b_out_ready;

   // instance C: external select, 3 channels
   logic [23:0] c_in_data;
   logic [2:0]  c_in_valid, c_in_ready;
   logic [1:0]  c_sel, c_out_chan;
   logic [7:0]  c_out_data;
   logic        c_out_valid, c_out_ready;

   int total = 0;
   int bad   = 0;

   mux_nt1_stream #(.WIDTH(8), .N(4), .MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan));

   mux_nt1_stream #(.WIDTH(8), .N(4), .MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan));

   mux_nt1_stream #(.WIDTH(8), .N(3), .MODE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_chan(c_out_chan));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      a_in_data   = 32'h44A52211; a_in_valid = 4'b1111; a_sel = 2'd0; a_out_ready = 1'b1;
      b_in_data   = 32'hD3C2B1A0; b_in_valid = 4'b1111; b_sel = 2'd0; b_out_ready = 1'b1;
      c_in_data   = 24'h332211;   c_in_valid = 3'b000;  c_sel = 2'd0; c_out_ready = 1'b1;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("a_rst_ready", a_in_ready, 4'b0000);
      check("b_rst_ready", b_in_ready, 4'b0000);
      check("a_rst_valid", a_out_valid, 1'b0);
      check("a_rst_data",  a_out_data, 8'h00);
      check("a_rst_chan",  a_out_chan, 2'd0);
      check("b_rst_valid", b_out_valid, 1'b0);
      check("c_rst_valid", c_out_valid, 1'b0);

      a_in_valid = 4'b0000;
      b_in_valid = 4'b0000;
      rst_n      = 1'b1;
      tick();
      check("a_idle_valid", a_out_valid, 1'b0);

      // ---------------- A: MODE 0 basic transfer ----------------
      a_sel = 2'd2; a_in_valid = 4'b0100; a_out_ready = 1'b1;
      #1;
      check("a_sel2_ready", a_in_ready, 4'b0100);
      tick();
      check("a_sel2_valid", a_out_valid, 1'b1);
      check("a_sel2_data",  a_out_data, 8'hA5);
      check("a_sel2_chan",  a_out_chan, 2'd2);

      // ---------------- A: backpressure then back-to-back replace ----------------
      a_in_data = 32'h445A2211; a_out_ready = 1'b0;
      #1;
      check("a_bp_ready", a_in_ready, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("a_bp_valid", a_out_valid, 1'b1);
         check("a_bp_data",  a_out_data, 8'hA5);
         check("a_bp_ready_hold", a_in_ready, 4'b0000);
      end
      a_out_ready = 1'b1;
      #1;
      check("a_b2b_ready", a_in_ready, 4'b0100);
      tick();
      check("a_b2b_valid", a_out_valid, 1'b1);
      check("a_b2b_data",  a_out_data, 8'h5A);
      check("a_b2b_chan",  a_out_chan, 2'd2);

      // drain with no new input
      a_in_valid = 4'b0000;
      tick();
      check("a_drain_valid", a_out_valid, 1'b0);

      // ready independent of valid
      a_sel = 2'd1; a_out_ready = 1'b0;
      #1;
      check("a_noval_ready", a_in_ready, 4'b0010);
      tick();
      check("a_noval_valid", a_out_valid, 1'b0);

      // highest channel
      a_sel = 2'd3; a_in_valid = 4'b1000; a_out_ready = 1'b1;
      #1;
      check("a_sel3_ready", a_in_ready, 4'b1000);
      tick();
      check("a_sel3_data", a_out_data, 8'h44);
      check("a_sel3_chan", a_out_chan, 2'd3);
      a_in_valid = 4'b0000;
      tick();
      check("a_end_valid", a_out_valid, 1'b0);

      // ---------------- B: round-robin from reset ----------------
      b_in_valid = 4'b1111; b_out_ready = 1'b1;
      #1;
      check("b_rr_ready0", b_in_ready, 4'b0001);
      tick();
      check("b_rr_chan0", b_out_chan, 2'd0);
      check("b_rr_data0", b_out_data, 8'hA0);
      check("b_rr_ready1", b_in_ready, 4'b0010);
      tick();
      check("b_rr_chan1", b_out_chan, 2'd1);
      tick();
      check("b_rr_chan2", b_out_chan, 2'd2);
      check("b_rr_data2", b_out_data, 8'hC2);
      tick();
      check("b_rr_chan3", b_out_chan, 2'd3);
      tick();
      check("b_rr_chan0b", b_out_chan, 2'd0);
      check("b_rr_valid", b_out_valid, 1'b1);

      // ptr=1: only ch2 valid -> grant 2, ptr becomes 3
      b_in_valid = 4'b0100;
      #1;
      check("b_skip_ready", b_in_ready, 4'b0100);
      tick();
      check("b_skip_chan", b_out_chan, 2'd2);

      // ptr=3 with ch0/ch1 valid -> wrap to 0, then 1
      b_in_valid = 4'b0011;
      #1;
      check("b_wrap_ready", b_in_ready, 4'b0001);
      tick();
      check("b_wrap_chan", b_out_chan, 2'd0);
      check("b_wrap_data", b_out_data, 8'hA0);
      check("b_next_ready", b_in_ready, 4'b0010);
      tick();
      check("b_next_chan", b_out_chan, 2'd1);
      check("b_next_data", b_out_data, 8'hB1);

      // stall: no ready, no pointer movement
      b_in_valid = 4'b1111; b_out_ready = 1'b0;
      #1;
      check("b_stall_ready", b_in_ready, 4'b0000);
      tick();
      check("b_stall_chan",  b_out_chan, 2'd1);
      check("b_stall_valid", b_out_valid, 1'b1);
      b_out_ready = 1'b1;
      #1;
      check("b_ptr_hold_ready", b_in_ready, 4'b0100);

      // ---------------- mid-operation reset (B holds a beat) ----------------
      rst_n = 1'b0;
      #1;
      check("b_inrst_ready", b_in_ready, 4'b0000);
      tick();
      check("b_rst_valid2", b_out_valid, 1'b0);
      check("b_rst_data2",  b_out_data, 8'h00);
      check("b_rst_chan2",  b_out_chan, 2'd0);
      rst_n = 1'b1;
      #1;
      check("b_post_rst_ready", b_in_ready, 4'b0001);
      tick();
      check("b_post_rst_chan", b_out_chan, 2'd0);
      check("b_post_rst_data", b_out_data, 8'hA0);
      b_in_valid = 4'b0000;
      tick();
      check("b_drain_valid", b_out_valid, 1'b0);

      // ---------------- C: N=3, out-of-range select ----------------
      c_sel = 2'd3; c_in_valid = 3'b111; c_out_ready = 1'b1;
      #1;
      check("c_oor_ready", c_in_ready, 3'b000);
      tick();
      check("c_oor_valid", c_out_valid, 1'b0);
      tick();
      check("c_oor_valid2", c_out_valid, 1'b0);
      c_sel = 2'd1;
      #1;
      check("c_sel1_ready", c_in_ready, 3'b010);
      tick();
      check("c_sel1_data", c_out_data, 8'h22);
      check("c_sel1_chan", c_out_chan, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_nt1_stream.md
MUX_NT1_STREAM -- requirements
Module: mux_nt1_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter MODE, default 0: 0 = external select, 1 = round-robin.
REQ-004 SHALL use local SELW = max(1, clog2(N)).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port in_data, input, N*WIDTH, channel i on bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, N, per-channel valid.
REQ-009 SHALL have port in_ready, output, N, per-channel ready.
REQ-010 SHALL have port sel, input, SELW, channel select, used in MODE 0 only.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.
REQ-014 SHALL have port out_chan, output, SELW, source channel of the current out_data.

Function
REQ-015 SHALL hold one beat in a single output register (data, chan, valid).
REQ-016 SHALL define can_accept = !out_valid || out_ready.
REQ-017 SHALL transfer on channel i when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-018 SHALL load the granted beat into the output register on the edge after the input transfer, giving 1-cycle latency, and set out_valid=1.
REQ-019 SHALL clear out_valid after an output transfer when no new input transfer occurs in the same cycle.
REQ-020 SHALL sustain one beat per cycle when out_ready=1, with a simultaneous drain and load replacing the register contents.
REQ-021 SHALL keep out_data and out_chan stable while out_valid && !out_ready.
REQ-022 SHALL assert at most one in_ready bit per cycle, and SHALL drive in_ready combinationally from the current state and inputs.
REQ-023 MODE 0: in_ready[i] SHALL be can_accept && (sel==i), with sel sampled in the transfer cycle only.
REQ-024 MODE 0: when sel>=N, in_ready SHALL be all zero and no beat SHALL be accepted.
REQ-025 MODE 0: in_ready[sel] SHALL be allowed high while in_valid[sel]=0, independent of valid.
REQ-026 MODE 1: the block SHALL keep a round-robin pointer ptr (SELW bits, range 0..N-1).
REQ-027 MODE 1: the grant SHALL go to the first i with in_valid[i]=1, scanning ptr, ptr+1, ... with wrap modulo N.
REQ-028 MODE 1: in_ready[grant] SHALL be can_accept, and in_ready SHALL be all zero when no channel is valid.
REQ-029 MODE 1: on each transfer, ptr SHALL become (grant+1) mod N, wrapping from N-1 to 0, and ptr SHALL not change without a transfer.
REQ-030 MODE 1: in_ready SHALL be all zero while can_accept=0, and the grant SHALL be recomputed every cycle until a transfer happens.
REQ-031 SHALL set out_chan to the index of the channel that supplied the beat.

Reset
REQ-032 SHALL, on a rising clk edge with rst_n=0, set out_valid=0, out_data=0, out_chan=0 and ptr=0.
REQ-033 SHALL, when reset is applied mid-operation, discard any held beat, and SHALL not produce a transfer on that edge.
REQ-034 SHALL hold in_ready all zero while rst_n=0.

Verification
REQ-035 SHALL cover this MODE 0 case: N=4, WIDTH=8, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1. Required response: in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2.
REQ-036 SHALL cover this MODE 0 case: sel=2, out_valid=1, out_ready=0 for 3 cycles. Required response: in_ready=0; out_data stays stable. Then out_ready=1 with a new beat. Required response: a back-to-back replace with out_valid staying 1.
REQ-037 SHALL cover this MODE 1 case: N=4, all in_valid=1, out_ready=1, from reset. Required response: grants on out_chan in order 0,1,2,3,0 on successive cycles.
REQ-038 SHALL cover this MODE 1 case: ptr=3, in_valid=4'b0011. Required response: grant 0 (wrap); then ptr=1 and the next grant is 1.
REQ-039 SHALL cover this N=3 MODE 0 case: sel=3, in_valid=3'b111. Required response: in_ready=0, out_valid stays 0.
REQ-040 SHALL cover this reset case: rst_n=0 for one edge while out_valid=1. Required response: out_valid=0, out_data=0, out_chan=0, ptr=0; the first grant after release is channel 0.
